// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline datapath: ALU opcodes, register-number width
// and the operand-forwarding select encoding.
package mips_pkg;

  localparam int REG_AW = 5;
  localparam int ALU_CW = 3;

  localparam logic [ALU_CW-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CW-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CW-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CW-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CW-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forwarding select for the two EX source registers.
// EX/MEM is checked first so the youngest in-flight value wins; register 0 never forwards.
module forward_unit #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_wa,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_wa,
  output mips_pkg::fwd_sel_t fwd_a,
  output mips_pkg::fwd_sel_t fwd_b
);
  import mips_pkg::*;

  logic [REG_AW-1:0] src_reg [2];
  fwd_sel_t          sel     [2];

  assign src_reg[0] = rs;
  assign src_reg[1] = rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign sel[gi] = (exmem_reg_write && (exmem_wa != '0) && (exmem_wa == src_reg[gi])) ? FWD_MEM :
                     (memwb_reg_write && (memwb_wa != '0) && (memwb_wa == src_reg[gi])) ? FWD_WB  :
                                                                                           FWD_RF;
  end

  assign fwd_a = sel[0];
  assign fwd_b = sel[1];

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX-side operand forwarding.
// Flush or hazard loads a bubble; forwarded operands are combinational after the register.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int ALU_CW     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rs,
  input  logic [REG_AW-1:0]     id_rt,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic                  id_uses_rt,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [ALU_CW-1:0]     id_alu_ctrl,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_branch,
  input  logic                  exmem_reg_write,
  input  logic [REG_AW-1:0]     exmem_wa,
  input  logic [DATA_WIDTH-1:0] exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_AW-1:0]     memwb_wa,
  input  logic [DATA_WIDTH-1:0] memwb_result,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [ALU_CW-1:0]     alu_ctrl,
  output logic [DATA_WIDTH-1:0] store_data,
  output logic [REG_AW-1:0]     ex_wa,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_branch
);
  import mips_pkg::*;

  logic                  valid_q, valid_d;
  logic [REG_AW-1:0]     rs_q, rs_d, rt_q, rt_d, wa_q, wa_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [ALU_CW-1:0]     alu_ctrl_q, alu_ctrl_d;
  logic                  alu_src_q, alu_src_d;
  logic                  reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic                  branch_q, branch_d;

  logic                  hazard;
  fwd_sel_t              fwd_a, fwd_b;
  logic [DATA_WIDTH-1:0] fwd_a_val, fwd_b_val;

  // The load's destination is only known once it sits in EX, so the stall is raised here.
  assign hazard = valid_q && mem_read_q && (wa_q != '0) && id_valid &&
                  ((wa_q == id_rs) || (id_uses_rt && (wa_q == id_rt)));
  assign stall  = hazard && !flush;

  always_comb begin
    valid_d      = id_valid;
    rs_d         = id_rs;
    rt_d         = id_rt;
    wa_d         = id_reg_dst ? id_rd : id_rt;
    rd1_d        = id_rd1;
    rd2_d        = id_rd2;
    imm_d        = id_imm;
    alu_ctrl_d   = id_alu_ctrl;
    alu_src_d    = id_alu_src;
    reg_write_d  = id_reg_write;
    mem_read_d   = id_mem_read;
    mem_write_d  = id_mem_write;
    mem_to_reg_d = id_mem_to_reg;
    branch_d     = id_branch;
    if (flush || hazard) begin
      valid_d      = 1'b0;
      rs_d         = '0;
      rt_d         = '0;
      wa_d         = '0;
      rd1_d        = '0;
      rd2_d        = '0;
      imm_d        = '0;
      alu_ctrl_d   = '0;
      alu_src_d    = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      branch_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      wa_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      wa_q         <= wa_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      branch_q     <= branch_d;
    end
  end

  forward_unit #(.REG_AW(REG_AW)) u_fwd (
    .rs              (rs_q),
    .rt              (rt_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_wa        (exmem_wa),
    .memwb_reg_write (memwb_reg_write),
    .memwb_wa        (memwb_wa),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always_comb begin
    fwd_a_val = rd1_q;
    fwd_b_val = rd2_q;
    case (fwd_a)
      FWD_MEM: fwd_a_val = exmem_result;
      FWD_WB:  fwd_a_val = memwb_result;
      default: fwd_a_val = rd1_q;
    endcase
    case (fwd_b)
      FWD_MEM: fwd_b_val = exmem_result;
      FWD_WB:  fwd_b_val = memwb_result;
      default: fwd_b_val = rd2_q;
    endcase
  end

  assign alu_a         = fwd_a_val;
  assign alu_b         = alu_src_q ? imm_q : fwd_b_val;
  assign store_data    = fwd_b_val;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_wa         = wa_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_branch     = branch_q;

endmodule
